// File: rtl/rtc_pkg.sv
// Shared types, limits and BCD validation for the time-of-day counter.
// Latency: n/a (package).
// Backpressure: n/a.
package rtc_pkg;
    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd_pair_t;

    localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
    localparam bcd_digit_t DIGIT_MAX    = 4'd9;
    localparam bcd_pair_t  HR24_MAX     = 8'h23;
    localparam bcd_pair_t  HR12_MAX     = 8'h12;
    localparam bcd_pair_t  HR12_MIN     = 8'h01;
    localparam int         SNOOZE_TICKS = 300;

    // Both nibbles decimal and the pair not above max; for well-formed BCD
    // a plain binary compare orders the same way as the decimal value.
    function automatic logic bcd_pair_valid(input bcd_pair_t value, input bcd_pair_t max);
        return (value[7:4] <= DIGIT_MAX) && (value[3:0] <= DIGIT_MAX) && (value <= max);
    endfunction
endpackage

// File: rtl/rtc_hms_alarm_bcd_digit.sv
// One BCD digit counting 0..MAX with carry out, synchronous clear and load.
// Latency: count updates on the edge after en/load; carry is combinational.
// Backpressure: none, en advances unconditionally.
module bcd_digit
    import rtc_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic       clk_1hz,
    input  logic       clr,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] count,
    output logic       carry
);
    assign carry = en && (count == MAX);

    // Digit register: clear beats load beats increment.
    always_ff @(posedge clk_1hz) begin
        if (clr) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= (count == MAX) ? 4'd0 : count + 4'd1;
        end
    end
endmodule

// File: rtl/rtc_hms_alarm.sv
// BCD hh:mm:ss clock, 12/24 h, prescaled tick, validated load, armed hh:mm alarm (snooze under RTC_SNOOZE_EN).
// Latency: a tick or load shows on the digits at the next clk_1hz edge; alarm_out rises on the edge that reaches hh:mm:00.
// Backpressure: none; load and alarm writes are accepted every cycle, run=0 freezes time.
module rtc_hms_alarm
    import rtc_pkg::*;
#(
    parameter int MODE_24H  = 1,
    parameter int TICK_DIV  = 1,
    parameter int ALARM_LEN = 60
) (
    input  logic       clk_1hz,
    input  logic       rst,
    input  logic       run,
    input  logic       set_en,
    input  logic [7:0] set_hr,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    input  logic       set_pm,
    input  logic       alm_wr,
    input  logic [7:0] alm_hr,
    input  logic [7:0] alm_min,
    input  logic       alm_pm,
    input  logic       alm_disarm,
    input  logic       alarm_ack,
`ifdef RTC_SNOOZE_EN
    input  logic       snooze,
`endif
    output logic       set_err,
    output logic [3:0] hrm,
    output logic [3:0] hrl,
    output logic [3:0] minm,
    output logic [3:0] minl,
    output logic [3:0] secm,
    output logic [3:0] secl,
    output logic       pm,
    output logic       tick_sec,
    output logic       alarm_out
);
    localparam int             PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);
    localparam bcd_pair_t      MS_MAX  = {SEC_TENS_MAX, DIGIT_MAX};
    localparam bcd_pair_t      HR_RST  = (MODE_24H != 0) ? 8'h00 : HR12_MAX;
    localparam logic [7:0]     LEN8    = 8'(ALARM_LEN);

    logic [PW-1:0] presc;
    logic          tick_raw, tick, load, set_ok, hr_ok;
    logic          c_secl, c_secm, c_minl, c_minm;
    bcd_pair_t     hr_q, hr_inc, hr_new, min_new;
    logic          pm_q, pm_inc, pm_new;
    bcd_pair_t     alm_hr_q, alm_min_q;
    logic          alm_pm_q, armed, alarm_match;
    logic [7:0]    alm_left;
`ifdef RTC_SNOOZE_EN
    logic [8:0]    snz_left;
    logic          snz_pend, snz_fire;
`endif

    // Load validation: hour range depends on the display mode.
    assign hr_ok  = (MODE_24H != 0) ? bcd_pair_valid(set_hr, HR24_MAX)
                                    : (bcd_pair_valid(set_hr, HR12_MAX) && (set_hr >= HR12_MIN));
    assign set_ok = hr_ok && bcd_pair_valid(set_min, MS_MAX) && bcd_pair_valid(set_sec, MS_MAX);
    assign load   = set_en && set_ok;

    // A valid load swallows the tick that would have happened on the same edge.
    assign tick_raw = run && (presc == PRE_MAX);
    assign tick     = tick_raw && !load;

    // Prescaler: free-runs only while run=1, restarts the second on a load.
    always_ff @(posedge clk_1hz) begin
        if (!rst || load) begin
            presc <= '0;
        end else if (run) begin
            presc <= tick_raw ? '0 : presc + PW'(1);
        end
    end

    bcd_digit #(.MAX(DIGIT_MAX)) u_secl (
        .clk_1hz(clk_1hz), .clr(!rst), .en(tick), .load(load),
        .load_val(set_sec[3:0]), .count(secl), .carry(c_secl));
    bcd_digit #(.MAX(SEC_TENS_MAX)) u_secm (
        .clk_1hz(clk_1hz), .clr(!rst), .en(c_secl), .load(load),
        .load_val(set_sec[7:4]), .count(secm), .carry(c_secm));
    bcd_digit #(.MAX(DIGIT_MAX)) u_minl (
        .clk_1hz(clk_1hz), .clr(!rst), .en(c_secm), .load(load),
        .load_val(set_min[3:0]), .count(minl), .carry(c_minl));
    bcd_digit #(.MAX(SEC_TENS_MAX)) u_minm (
        .clk_1hz(clk_1hz), .clr(!rst), .en(c_minl), .load(load),
        .load_val(set_min[7:4]), .count(minm), .carry(c_minm));

    // Next hour value: 24 h wraps 23->00, 12 h runs 11->12 (pm flips) and 12->01.
    always_comb begin
        hr_inc = hr_q;
        pm_inc = pm_q;
        if (MODE_24H != 0) begin
            if (hr_q == HR24_MAX)            hr_inc = 8'h00;
            else if (hr_q[3:0] == DIGIT_MAX) hr_inc = {hr_q[7:4] + 4'd1, 4'd0};
            else                             hr_inc = {hr_q[7:4], hr_q[3:0] + 4'd1};
        end else begin
            if (hr_q == HR12_MAX) begin
                hr_inc = HR12_MIN;
            end else if (hr_q == 8'h11) begin
                hr_inc = HR12_MAX;
                pm_inc = !pm_q;
            end else if (hr_q[3:0] == DIGIT_MAX) begin
                hr_inc = {hr_q[7:4] + 4'd1, 4'd0};
            end else begin
                hr_inc = {hr_q[7:4], hr_q[3:0] + 4'd1};
            end
        end
    end

    // Hour and pm register; pm is forced to 0 in 24 h mode.
    always_ff @(posedge clk_1hz) begin
        if (!rst) begin
            hr_q <= HR_RST;
            pm_q <= 1'b0;
        end else if (load) begin
            hr_q <= set_hr;
            pm_q <= (MODE_24H != 0) ? 1'b0 : set_pm;
        end else if (c_minm) begin
            hr_q <= hr_inc;
            pm_q <= pm_inc;
        end
    end

    // Time the counter will show after a seconds rollover, for the alarm compare.
    always_comb begin
        min_new = {minm, minl};
        if (minl == DIGIT_MAX) min_new = (minm == SEC_TENS_MAX) ? 8'h00 : {minm + 4'd1, 4'd0};
        else                   min_new = {minm, minl + 4'd1};
    end
    assign hr_new = ({minm, minl} == MS_MAX) ? hr_inc : hr_q;
    assign pm_new = ({minm, minl} == MS_MAX) ? pm_inc : pm_q;

    // Only a counted rollover can match; c_secm already implies a real tick.
    assign alarm_match = armed && c_secm && (min_new == alm_min_q) && (hr_new == alm_hr_q)
                         && ((MODE_24H != 0) || (pm_new == alm_pm_q));

    // Alarm setpoint and arm flag; disarm beats a simultaneous write.
    always_ff @(posedge clk_1hz) begin
        if (!rst) begin
            armed     <= 1'b0;
            alm_hr_q  <= HR_RST;
            alm_min_q <= 8'h00;
            alm_pm_q  <= 1'b0;
        end else if (alm_disarm) begin
            armed <= 1'b0;
        end else if (alm_wr) begin
            armed     <= 1'b1;
            alm_hr_q  <= alm_hr;
            alm_min_q <= alm_min;
            alm_pm_q  <= alm_pm;
        end
    end

`ifdef RTC_SNOOZE_EN
    assign snz_fire = snz_pend && tick && (snz_left == 9'd1);

    // Snooze countdown in ticks; cancelled by ack, disarm or a fresh match.
    always_ff @(posedge clk_1hz) begin
        if (!rst) begin
            snz_pend <= 1'b0;
            snz_left <= 9'd0;
        end else if (alarm_ack || alm_disarm || alarm_match) begin
            snz_pend <= 1'b0;
        end else if (snooze && alarm_out) begin
            snz_pend <= 1'b1;
            snz_left <= 9'(SNOOZE_TICKS);
        end else if (snz_pend && tick) begin
            if (snz_left == 9'd1) snz_pend <= 1'b0;
            snz_left <= snz_left - 9'd1;
        end
    end
`endif

    // Alarm output with tick-based hold time; ack/disarm win over a match.
    always_ff @(posedge clk_1hz) begin
        if (!rst) begin
            alarm_out <= 1'b0;
            alm_left  <= 8'd0;
        end else if (alarm_ack || alm_disarm) begin
            alarm_out <= 1'b0;
        end else if (alarm_match) begin
            alarm_out <= 1'b1;
            alm_left  <= LEN8;
`ifdef RTC_SNOOZE_EN
        end else if (snooze && alarm_out) begin
            alarm_out <= 1'b0;
        end else if (snz_fire) begin
            alarm_out <= 1'b1;
            alm_left  <= LEN8;
`endif
        end else if (alarm_out && tick) begin
            if (alm_left == 8'd1) alarm_out <= 1'b0;
            alm_left <= alm_left - 8'd1;
        end
    end

    // Registered status pulses.
    always_ff @(posedge clk_1hz) begin
        if (!rst) begin
            tick_sec <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            tick_sec <= tick;
            set_err  <= set_en && !set_ok;
        end
    end

    assign hrm = hr_q[7:4];
    assign hrl = hr_q[3:0];
    assign pm  = pm_q;
endmodule

// File: tb/tb_rtc_hms_alarm.sv
// Two clock instances (24 h / 12 h) share one randomized input stream and
// are checked against a seconds-of-day reference model via a scoreboard.
module tb_rtc_hms_alarm;
    typedef struct packed {
        logic [23:0] t;
        logic        pm;
        logic        tk;
        logic        ao;
        logic        se;
    } obs_t;

    logic       clk_1hz;
    logic       rst, run, set_en, set_pm, alm_wr, alm_pm, alm_disarm, alarm_ack;
    logic [7:0] set_hr, set_min, set_sec, alm_hr, alm_min;

    logic [3:0] a_hrm, a_hrl, a_minm, a_minl, a_secm, a_secl;
    logic [3:0] b_hrm, b_hrl, b_minm, b_minl, b_secm, b_secl;
    logic       a_pm, a_tk, a_ao, a_se, b_pm, b_tk, b_ao, b_se;

    int total = 0;
    int bad   = 0;

    obs_t q24[$];
    obs_t q12[$];

    // reference model state, index 0 = 24 h instance, 1 = 12 h instance
    int         sod[2];
    int         presc[2];
    int         remain[2];
    bit         armed[2];
    bit         aout[2];
    logic [7:0] ahr[2];
    logic [7:0] amin[2];
    bit         apm[2];

    rtc_hms_alarm #(.MODE_24H(1), .TICK_DIV(1), .ALARM_LEN(5)) u24 (
        .clk_1hz(clk_1hz), .rst(rst), .run(run), .set_en(set_en),
        .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec), .set_pm(set_pm),
        .set_err(a_se), .alm_wr(alm_wr), .alm_hr(alm_hr), .alm_min(alm_min),
        .alm_pm(alm_pm), .alm_disarm(alm_disarm), .alarm_ack(alarm_ack),
        .hrm(a_hrm), .hrl(a_hrl), .minm(a_minm), .minl(a_minl), .secm(a_secm),
        .secl(a_secl), .pm(a_pm), .tick_sec(a_tk), .alarm_out(a_ao));

    rtc_hms_alarm #(.MODE_24H(0), .TICK_DIV(4), .ALARM_LEN(3)) u12 (
        .clk_1hz(clk_1hz), .rst(rst), .run(run), .set_en(set_en),
        .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec), .set_pm(set_pm),
        .set_err(b_se), .alm_wr(alm_wr), .alm_hr(alm_hr), .alm_min(alm_min),
        .alm_pm(alm_pm), .alm_disarm(alm_disarm), .alarm_ack(alarm_ack),
        .hrm(b_hrm), .hrl(b_hrl), .minm(b_minm), .minl(b_minl), .secm(b_secm),
        .secl(b_secl), .pm(b_pm), .tick_sec(b_tk), .alarm_out(b_ao));

    initial clk_1hz = 1'b0;
    always #5 clk_1hz = ~clk_1hz;

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [7:0] b);
        return (b[7:4] < 4'd10) && (b[3:0] < 4'd10);
    endfunction

    function automatic logic [7:0] int2bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // displayed hour for a seconds-of-day value
    function automatic int disp_hr(input int i, input int s);
        int h;
        h = s / 3600;
        if (i == 0) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    function automatic bit disp_pm(input int i, input int s);
        return (i != 0) && (s / 3600 >= 12);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step(input int i, output obs_t o);
        int hr, mi, se, dv, len;
        bit valid, ld, tk, serr, match;
        dv  = (i == 0) ? 1 : 4;
        len = (i == 0) ? 5 : 3;
        tk = 1'b0;
        serr = 1'b0;
        if (!rst) begin
            sod[i] = 0; presc[i] = 0; remain[i] = 0;
            armed[i] = 1'b0; aout[i] = 1'b0;
            ahr[i] = (i == 0) ? 8'h00 : 8'h12; amin[i] = 8'h00; apm[i] = 1'b0;
        end else begin
            hr = bcd2int(set_hr); mi = bcd2int(set_min); se = bcd2int(set_sec);
            valid = bcd_ok(set_hr) && bcd_ok(set_min) && bcd_ok(set_sec) && mi < 60 && se < 60
                    && ((i == 0) ? (hr <= 23) : (hr >= 1 && hr <= 12));
            ld   = set_en && valid;
            serr = set_en && !valid;
            tk   = run && (presc[i] == dv - 1) && !ld;
            if (ld) presc[i] = 0;
            else if (run) presc[i] = (presc[i] + 1) % dv;
            if (ld) sod[i] = ((i == 0) ? hr : (hr % 12) + (set_pm ? 12 : 0)) * 3600 + mi * 60 + se;
            else if (tk) sod[i] = (sod[i] + 1) % 86400;
            match = armed[i] && tk && (sod[i] % 60 == 0)
                    && (int2bcd(disp_hr(i, sod[i])) == ahr[i])
                    && (int2bcd((sod[i] / 60) % 60) == amin[i])
                    && ((i == 0) || (disp_pm(i, sod[i]) == apm[i]));
            if (alarm_ack || alm_disarm) aout[i] = 1'b0;
            else if (match) begin aout[i] = 1'b1; remain[i] = len; end
            else if (aout[i] && tk) begin
                remain[i]--;
                if (remain[i] == 0) aout[i] = 1'b0;
            end
            if (alm_disarm) armed[i] = 1'b0;
            else if (alm_wr) begin
                armed[i] = 1'b1; ahr[i] = alm_hr; amin[i] = alm_min; apm[i] = alm_pm;
            end
        end
        o.t  = {int2bcd(disp_hr(i, sod[i])), int2bcd((sod[i] / 60) % 60), int2bcd(sod[i] % 60)};
        o.pm = disp_pm(i, sod[i]);
        o.tk = tk;
        o.ao = aout[i];
        o.se = serr;
    endtask

    // Issue one cycle: predict, enqueue, wait for the next drive point, drop pulses.
    task automatic step();
        obs_t e0, e1;
        model_step(0, e0);
        model_step(1, e1);
        q24.push_back(e0);
        q12.push_back(e1);
        @(negedge clk_1hz);
        set_en = 1'b0; alm_wr = 1'b0; alm_disarm = 1'b0; alarm_ack = 1'b0;
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
        set_en = 1'b1; set_hr = h; set_min = m; set_sec = s; set_pm = p;
        step();
    endtask

    task automatic cmp(input string nm, input int i, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h exp=%h at %0t", nm, i, got, exp, $time);
        end
    endtask

    task automatic check_obs(input int i, input obs_t got, input obs_t exp);
        cmp("time", i, got.t, exp.t);
        cmp("pm", i, 24'(got.pm), 24'(exp.pm));
        cmp("tick_sec", i, 24'(got.tk), 24'(exp.tk));
        cmp("alarm_out", i, 24'(got.ao), 24'(exp.ao));
        cmp("set_err", i, 24'(got.se), 24'(exp.se));
    endtask

    // Monitor: after every active edge, pop the prediction for that edge and compare.
    initial begin
        obs_t g, e;
        forever begin
            @(posedge clk_1hz);
            #1;
            if (q24.size() > 0) begin
                e = q24.pop_front();
                g = '{t: {a_hrm, a_hrl, a_minm, a_minl, a_secm, a_secl}, pm: a_pm, tk: a_tk, ao: a_ao, se: a_se};
                check_obs(0, g, e);
            end
            if (q12.size() > 0) begin
                e = q12.pop_front();
                g = '{t: {b_hrm, b_hrl, b_minm, b_minl, b_secm, b_secl}, pm: b_pm, tk: b_tk, ao: b_ao, se: b_se};
                check_obs(1, g, e);
            end
        end
    end

    initial begin
        int h, m;
        rst = 1'b0; run = 1'b0; set_en = 1'b0; set_pm = 1'b0;
        alm_wr = 1'b0; alm_pm = 1'b0; alm_disarm = 1'b0; alarm_ack = 1'b0;
        set_hr = 8'h00; set_min = 8'h00; set_sec = 8'h00; alm_hr = 8'h00; alm_min = 8'h00;

        // reset, free count, reset mid-count
        step(); step();
        rst = 1'b1; run = 1'b1;
        repeat (3) step();
        rst = 1'b0; step(); rst = 1'b1;
        repeat (2) step();

        // wraps
        load(8'h23, 8'h59, 8'h58, 1'b0); repeat (3) step();
        load(8'h11, 8'h59, 8'h59, 1'b0); repeat (5) step();
        load(8'h12, 8'h59, 8'h59, 1'b1); repeat (5) step();
        load(8'h11, 8'h59, 8'h59, 1'b1); repeat (5) step();
        load(8'h09, 8'h59, 8'h59, 1'b0); repeat (5) step();
        load(8'h19, 8'h59, 8'h59, 1'b0); repeat (2) step();

        // invalid loads
        load(8'h24, 8'h00, 8'h00, 1'b0); step();
        load(8'h10, 8'h6A, 8'h00, 1'b0); step();
        load(8'h00, 8'h10, 8'h00, 1'b0); step();
        load(8'h10, 8'h10, 8'h60, 1'b0); step();

        // alarm fire and timeout, then ack mid-way
        alm_wr = 1'b1; alm_hr = 8'h07; alm_min = 8'h30; alm_pm = 1'b0; step();
        load(8'h07, 8'h29, 8'h59, 1'b0); repeat (20) step();
        load(8'h07, 8'h29, 8'h59, 1'b0); repeat (6) step();
        alarm_ack = 1'b1; step(); repeat (4) step();
        load(8'h07, 8'h29, 8'h59, 1'b0); alarm_ack = 1'b1; step(); repeat (6) step();

        // freeze, then a loaded alarm time must not fire
        run = 1'b0; repeat (10) step();
        load(8'h07, 8'h30, 8'h00, 1'b0); repeat (3) step();
        run = 1'b1; repeat (8) step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r   = $urandom_range(0, 99);
            rst = ($urandom_range(0, 499) != 0);
            run = ($urandom_range(0, 7) != 0);
            alarm_ack  = ($urandom_range(0, 39) == 0);
            alm_disarm = ($urandom_range(0, 79) == 0);
            if (r < 3) begin
                h = $urandom_range(1, 12);
                m = $urandom_range(1, 59);
                alm_wr = 1'b1; alm_hr = int2bcd(h); alm_min = int2bcd(m); alm_pm = 1'($urandom);
                step();
                load(int2bcd(h), int2bcd(m - 1), 8'h55 + 8'($urandom_range(0, 4)), alm_pm);
            end else if (r < 9) begin
                set_en  = 1'b1;
                set_hr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : int2bcd($urandom_range(0, 23));
                set_min = ($urandom_range(0, 3) == 0) ? 8'($urandom) : int2bcd($urandom_range(0, 59));
                set_sec = ($urandom_range(0, 1) == 0) ? 8'h59 : int2bcd($urandom_range(0, 59));
                set_pm  = 1'($urandom);
                step();
            end else begin
                step();
            end
        end

        // drain the scoreboard
        repeat (2) @(posedge clk_1hz);
        #2;
        total++;
        if (q24.size() != 0 || q12.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d pending exp=0", q24.size(), q12.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
